flog_ctrl: RTL
==============

Name: flog_ctrl

Overview:
- Front-end sequencer for the bfloat16 natural-log unit. Accepts one operand per transaction over a valid/ready handshake.
- Classifies the operand with an instantiated special_case_detector. Special operands are resolved locally with IEEE-754 results and flags.
- Ordinary operands are issued to the multi-cycle log datapath core over a start/done handshake. The result is held until the consumer accepts it.

Parameters:
- EXP_WIDTH, 8, exponent width passed to the detector.
- FRACT_WIDTH, 7, fraction width passed to the detector.
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before abort. Used only with FLOG_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- op_valid_i  in  1  operand valid.
- op_ready_o  out  1  controller can accept an operand.
- op_i  in  16  bfloat16 operand {s, exp[7:0], fract[6:0]}.
- core_start_o  out  1  one-cycle start pulse to the log core.
- core_op_o  out  16  operand to the core, held stable from start until done.
- core_done_i  in  1  core result valid, single-cycle pulse.
- core_res_i  in  16  core result, sampled only when core_done_i=1 in WAIT.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  consumer accepts the result.
- res_o  out  16  bfloat16 result.
- invalid_o  out  1  invalid-operation flag, qualified by res_valid_o.
- divzero_o  out  1  divide-by-zero flag, qualified by res_valid_o.
- special_o  out  1  result produced by the bypass path, not the core.
- busy_o  out  1  state != IDLE.

Behaviour:
- Registers: op_q[15:0], res_q[15:0], flags_q[2:0], state. All outputs are driven from state and registers; there is no input-to-output combinational path.
- Reset (async, rst_ni=0):
  - state=IDLE, op_q=0, res_q=0, flags=0.
  - Outputs: op_ready_o=1, core_start_o=0, res_valid_o=0, busy_o=0, core_op_o=0x0000.
- Reset asserted mid-operation discards the transaction. The core shares rst_ni.

FSM:
- IDLE: op_ready_o=1. On op_valid_i, capture op_i into op_q and go to DECODE.
- DECODE: one cycle. Detector evaluates op_q.
  - If special: load res_q and flags, go to RESP.
  - Else: core_start_o=1 for this cycle only, go to WAIT.
- WAIT: core_start_o=0. On core_done_i: res_q=core_res_i, flags=0, special=0, go to RESP.
- RESP: res_valid_o=1 and res_o=res_q. On res_ready_i, go to IDLE.
  - res_o and flags stay stable while res_valid_o=1 and res_ready_i=0.

Handshakes and latency:
- op_ready_o is 0 in DECODE, WAIT and RESP, so there is one transaction in flight at most.
- A new operand can be accepted no earlier than the cycle after the RESP handshake.
- core_done_i is ignored outside WAIT, including a stray pulse in IDLE, DECODE or RESP.
- Special path: accept at cycle N, res_valid_o=1 at N+2.
- Core path: start at N+1; done sampled at cycle M gives res_valid_o at M+1.

Special-case resolution (first match wins):
1. NaN (exp all-ones, fract!=0), either sign: res=0x7FC0. invalid=1 iff fract[6]=0 (signaling NaN).
2. Zero or denormal (exp=0), either sign: denormal flushed to zero; res=0xFF80 (-inf), divzero=1.
3. Sign=1 (negative finite or -inf): res=0x7FC0, invalid=1.
4. +inf: res=0x7F80, no flags.
5. Exactly 0x3F80 (+1.0): res=0x0000, no flags.
6. Otherwise: core path.

- special_o=1 for cases 1–5.
- core_op_o=op_q at all times, so it is stable throughout WAIT.

Optional Feature:
- Macro FLOG_TIMEOUT_EN.
- When defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on DECODE->WAIT and increments each WAIT cycle without core_done_i.
  - When the count reaches TIMEOUT_CYCLES with no done: res=0x7FC0, invalid=1, special=0, go to RESP.
  - Extra output timeout_o is set with this result, cleared on the RESP handshake, and reset to 0.
  - core_done_i arriving in the same cycle the count reaches TIMEOUT_CYCLES wins: the normal result is taken.
- When undefined: no counter and no timeout_o port; WAIT is unbounded.

Test Plan:
- Reset held, then released -> op_ready_o=1, res_valid_o=0, busy_o=0, core_start_o=0.
- op_i=0x8000 (-0), res_ready_i=1 -> res_valid_o at accept+2, res_o=0xFF80, divzero_o=1, invalid_o=0, special_o=1, no core_start_o.
- Sweep 0x7F81 (sNaN), 0x7FC0, 0xBF80 (-1.0), 0x7F80, 0x3F80, 0x0001 -> res_o respectively:
  - 0x7FC0 with invalid=1; 0x7FC0 with invalid=0; 0x7FC0 with invalid=1;
  - 0x7F80; 0x0000; 0xFF80 with divzero=1.
- op_i=0x4000 (2.0), core model returns 0x3F31 after 10 cycles:
  - core_start_o is a single pulse at accept+1 and core_op_o=0x4000 throughout WAIT.
  - res_o=0x3F31 with special_o=0; op_valid_i held high is refused until the handshake.
- Backpressure: res_ready_i=0 for 5 cycles in RESP -> res_o and flags stable, op_ready_o=0; stray core_done_i in RESP is ignored.
- Reset pulsed while in WAIT -> IDLE immediately, no res_valid_o. The next operand 0x4000 completes normally.
- With FLOG_TIMEOUT_EN, TIMEOUT_CYCLES=8, core never answers -> RESP after 8 WAIT cycles, res_o=0x7FC0, invalid_o=1, timeout_o=1.

Source files
------------

// File: rtl/flog_ctrl.sv
// flog_ctrl: front-end sequencer for the bfloat16 natural-log unit.
// Optional feature macro: FLOG_TIMEOUT_EN adds a bounded WAIT with a timeout_o flag.
// Ports:
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   op_valid_i, op_ready_o, op_i        operand handshake
//   core_start_o, core_op_o             issue to the multi-cycle log core
//   core_done_i, core_res_i             core completion pulse and result
//   res_valid_o, res_ready_i, res_o     result handshake
//   invalid_o, divzero_o, special_o     result flags, qualified by res_valid_o
//   timeout_o                           core did not answer in time (FLOG_TIMEOUT_EN only)
//   busy_o                              a transaction is in flight

// special_case_detector: resolves operands whose logarithm needs no core.
module special_case_detector #(
    parameter int EXP_WIDTH   = 8,
    parameter int FRACT_WIDTH = 7
) (
    input  logic [EXP_WIDTH+FRACT_WIDTH:0] op,
    output logic                           special,
    output logic [EXP_WIDTH+FRACT_WIDTH:0] res,
    output logic                           invalid,
    output logic                           divzero
);
    localparam logic [EXP_WIDTH+FRACT_WIDTH:0] QNAN = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(FRACT_WIDTH-1){1'b0}}};
    localparam logic [EXP_WIDTH+FRACT_WIDTH:0] NINF = {1'b1, {EXP_WIDTH{1'b1}}, {FRACT_WIDTH{1'b0}}};
    localparam logic [EXP_WIDTH+FRACT_WIDTH:0] PINF = {1'b0, {EXP_WIDTH{1'b1}}, {FRACT_WIDTH{1'b0}}};
    localparam logic [EXP_WIDTH+FRACT_WIDTH:0] ONE  = {2'b00, {(EXP_WIDTH-1){1'b1}}, {FRACT_WIDTH{1'b0}}};
    logic                   sign;
    logic [EXP_WIDTH-1:0]   ex;
    logic [FRACT_WIDTH-1:0] fr;
    logic                   ex_ones, ex_zero, nan;
    assign sign    = op[EXP_WIDTH+FRACT_WIDTH];
    assign ex      = op[EXP_WIDTH+FRACT_WIDTH-1:FRACT_WIDTH];
    assign fr      = op[FRACT_WIDTH-1:0];
    assign ex_ones = &ex;
    assign ex_zero = ~|ex;
    assign nan     = ex_ones & |fr;
    // Priority: NaN, zero/denormal (flushed), negative, +inf, exactly +1.0.
    assign special = ex_ones | ex_zero | sign | (op == ONE);
    assign res     = nan ? QNAN : ex_zero ? NINF : sign ? QNAN : ex_ones ? PINF : '0;
    // Only signaling NaNs (quiet bit clear) raise invalid on the NaN path.
    assign invalid = nan ? ~fr[FRACT_WIDTH-1] : (~ex_zero & sign);
    assign divzero = ~nan & ex_zero;
endmodule

module flog_ctrl #(
    parameter int EXP_WIDTH      = 8,
    parameter int FRACT_WIDTH    = 7,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           op_valid_i,
    output logic                           op_ready_o,
    input  logic [EXP_WIDTH+FRACT_WIDTH:0] op_i,
    output logic                           core_start_o,
    output logic [EXP_WIDTH+FRACT_WIDTH:0] core_op_o,
    input  logic                           core_done_i,
    input  logic [EXP_WIDTH+FRACT_WIDTH:0] core_res_i,
    output logic                           res_valid_o,
    input  logic                           res_ready_i,
    output logic [EXP_WIDTH+FRACT_WIDTH:0] res_o,
    output logic                           invalid_o,
    output logic                           divzero_o,
    output logic                           special_o,
`ifdef FLOG_TIMEOUT_EN
    output logic                           timeout_o,
`endif
    output logic                           busy_o
);
    localparam int W = EXP_WIDTH + FRACT_WIDTH + 1;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(FRACT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DECODE, WAIT, RESP} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] op_q, res_q;
    logic [2:0]   flags_q;
    logic         det_special, det_invalid, det_divzero;
    logic [W-1:0] det_res;
    logic         ld_op, ld_spec, ld_core;

    special_case_detector #(
        .EXP_WIDTH  (EXP_WIDTH),
        .FRACT_WIDTH(FRACT_WIDTH)
    ) u_det (
        .op     (op_q),
        .special(det_special),
        .res    (det_res),
        .invalid(det_invalid),
        .divzero(det_divzero)
    );

`ifdef FLOG_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic          timeout_q;
    logic          ld_to;
`endif

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;

    always_comb begin
        state_d      = state_q;
        ld_op        = 1'b0;
        ld_spec      = 1'b0;
        ld_core      = 1'b0;
        core_start_o = 1'b0;
`ifdef FLOG_TIMEOUT_EN
        ld_to        = 1'b0;
`endif
        unique case (state_q)
            IDLE: if (op_valid_i) begin
                ld_op   = 1'b1;
                state_d = DECODE;
            end
            DECODE: if (det_special) begin
                ld_spec = 1'b1;
                state_d = RESP;
            end else begin
                core_start_o = 1'b1;
                state_d      = WAIT;
            end
            WAIT: begin
                if (core_done_i) begin
                    ld_core = 1'b1;
                    state_d = RESP;
                end
`ifdef FLOG_TIMEOUT_EN
                // This cycle's increment would reach the limit; a done in the same cycle wins above.
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    ld_to   = 1'b1;
                    state_d = RESP;
                end
`endif
            end
            RESP: if (res_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // flags_q = {invalid, divzero, special}
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            op_q    <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            if (ld_op) op_q <= op_i;
            if (ld_spec) begin
                res_q   <= det_res;
                flags_q <= {det_invalid, det_divzero, 1'b1};
            end
            if (ld_core) begin
                res_q   <= core_res_i;
                flags_q <= '0;
            end
`ifdef FLOG_TIMEOUT_EN
            if (ld_to) begin
                res_q   <= QNAN;
                flags_q <= 3'b100;
            end
`endif
        end

`ifdef FLOG_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == DECODE) cnt_q <= '0;
            else if (state_q == WAIT && !core_done_i) cnt_q <= cnt_q + CW'(1);
            if (ld_to) timeout_q <= 1'b1;
            else if (state_q == RESP && res_ready_i) timeout_q <= 1'b0;
        end

    assign timeout_o = timeout_q;
`endif

    assign op_ready_o  = state_q == IDLE;
    assign busy_o      = state_q != IDLE;
    assign res_valid_o = state_q == RESP;
    assign core_op_o   = op_q;
    assign res_o       = res_q;
    assign invalid_o   = flags_q[2];
    assign divzero_o   = flags_q[1];
    assign special_o   = flags_q[0];
endmodule
